// File: rtl/siggen_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : siggen_pkg
//  Purpose  : Shared definitions for the signal-generator reporting path:
//             ASCII constants, the report FSM state encoding, message
//             lengths and the BCD add-3 adjust helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package siggen_pkg;

    localparam logic [7:0] CHAR_D     = 8'h44;
    localparam logic [7:0] CHAR_EQ    = 8'h3D;
    localparam logic [7:0] CHAR_PCT   = 8'h25;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_ZERO  = 8'h30;

    // Message lengths in bytes with and without the trailing CR/LF.
    localparam int MSG_LEN_NL   = 8;
    localparam int MSG_LEN_NONL = 6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_SEND    = 2'd2
    } state_t;

    // Double-dabble correction: any BCD nibble of 5 or more gets +3 so the
    // following left shift carries correctly into the next decade.
    function automatic logic [11:0] bcd_add3(input logic [11:0] bcd);
        logic [11:0] res;
        for (int i = 0; i < 3; i++) begin
            res[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? bcd[i*4 +: 4] + 4'd3
                                                    : bcd[i*4 +: 4];
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dt_bcd_serial.sv
`default_nettype none
// ============================================================================
//  Module   : dt_bcd_serial
//  Purpose  : Sequential 8-bit binary to 3-digit BCD converter using
//             shift-add-3, one bit per clock, eight clocks per conversion.
//  Ports    : clk      - system clock
//             rst      - asynchronous active-high reset
//             load     - latch bin and clear the BCD register
//             bin      - binary value to convert
//             bcd      - {hundreds, tens, units}, final after the 8th shift
//             bcd_done - high in the cycle whose closing edge does the
//                        8th shift (lets the caller change state on that
//                        same edge)
//  Revision : 1.0  initial release
// ============================================================================
module dt_bcd_serial
    import siggen_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [7:0]  bin,
    output logic [11:0] bcd,
    output logic        bcd_done
);

    logic [7:0]  r_sr;
    logic [11:0] r_bcd;
    logic [2:0]  r_cnt;
    logic        r_run;
    logic [11:0] w_adj;

    assign w_adj = bcd_add3(r_bcd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr  <= 8'd0;
            r_bcd <= 12'd0;
            r_cnt <= 3'd0;
            r_run <= 1'b0;
        end else if (load) begin
            r_sr  <= bin;
            r_bcd <= 12'd0;
            r_cnt <= 3'd0;
            r_run <= 1'b1;
        end else if (r_run) begin
            r_bcd <= {w_adj[10:0], r_sr[7]};
            r_sr  <= {r_sr[6:0], 1'b0};
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt == 3'd7) begin
                r_run <= 1'b0;
            end
        end
    end

    assign bcd      = r_bcd;
    assign bcd_done = r_run && (r_cnt == 3'd7);

endmodule
`default_nettype wire

// File: rtl/duty_report_tx.sv
`default_nettype none
// ============================================================================
//  Module   : duty_report_tx
//  Purpose  : On start, latches the duty value, converts it to BCD and
//             streams "D=ddd%" (optionally followed by CR LF) over a
//             valid/ready byte interface to the UART transmitter.
//  Params   : NEWLINE    - 1 appends CR LF (8 bytes), 0 gives 6 bytes
//             ZERO_BLANK - 1 prints leading zero hundreds/tens as spaces
//  Ports    : clk, rst  - clock, asynchronous active-high reset
//             start     - report request, sampled only when idle
//             dt        - duty value, latched when start is accepted
//             tx_data   - current message byte (0 when not sending)
//             tx_valid  - tx_data is valid
//             tx_ready  - byte accepted when tx_valid && tx_ready
//             busy      - high from acceptance to the last handshake
//             done      - one-cycle pulse after the last byte is accepted
//  Revision : 1.0  initial release
// ============================================================================
module duty_report_tx
    import siggen_pkg::*;
#(
    parameter bit NEWLINE    = 1'b1,
    parameter bit ZERO_BLANK = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] dt,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] c_last_idx = NEWLINE ? 3'(MSG_LEN_NL - 1)
                                                : 3'(MSG_LEN_NONL - 1);

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_idx;
    logic        r_done;
    logic        w_load;
    logic        w_hs;
    logic        w_last;
    logic [11:0] w_bcd;
    logic        w_bcd_done;
    logic [3:0]  w_hund;
    logic [3:0]  w_tens;
    logic [3:0]  w_units;
    logic        w_hund_blank;
    logic        w_tens_blank;
    logic [7:0]  w_byte;

    // The converter owns the latched copy of dt, so later changes on dt
    // cannot disturb a message in flight.
    dt_bcd_serial u_bcd (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .bin      (dt),
        .bcd      (w_bcd),
        .bcd_done (w_bcd_done)
    );

    assign w_load = (r_state == ST_IDLE) && start;
    assign w_hs   = tx_valid && tx_ready;
    assign w_last = (r_idx == c_last_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        tx_valid = 1'b0;
        busy     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                busy = 1'b1;
                if (w_bcd_done) begin
                    w_next = ST_SEND;
                end
            end
            ST_SEND: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                if (w_hs && w_last) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Byte index is zeroed on the edge that enters SEND and after the last
    // byte, so every message starts from byte 0 and reset state is 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx  <= 3'd0;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == ST_SEND) && w_hs && w_last;
            if ((r_state == ST_CONVERT) && w_bcd_done) begin
                r_idx <= 3'd0;
            end else if ((r_state == ST_SEND) && w_hs) begin
                r_idx <= w_last ? 3'd0 : r_idx + 3'd1;
            end
        end
    end

    assign done = r_done;

    assign w_hund       = w_bcd[11:8];
    assign w_tens       = w_bcd[7:4];
    assign w_units      = w_bcd[3:0];
    assign w_hund_blank = ZERO_BLANK && (w_hund == 4'd0);
    assign w_tens_blank = ZERO_BLANK && (w_hund == 4'd0) && (w_tens == 4'd0);

    always_comb begin
        w_byte = 8'h00;
        case (r_idx)
            3'd0: w_byte = CHAR_D;
            3'd1: w_byte = CHAR_EQ;
            3'd2: w_byte = w_hund_blank ? CHAR_SPACE : CHAR_ZERO + {4'd0, w_hund};
            3'd3: w_byte = w_tens_blank ? CHAR_SPACE : CHAR_ZERO + {4'd0, w_tens};
            3'd4: w_byte = CHAR_ZERO + {4'd0, w_units};
            3'd5: w_byte = CHAR_PCT;
            3'd6: w_byte = CHAR_CR;
            3'd7: w_byte = CHAR_LF;
            default: w_byte = 8'h00;
        endcase
    end

    // Driven from registered state/index only, so the byte cannot change
    // while waiting for tx_ready.
    assign tx_data = (r_state == ST_SEND) ? w_byte : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_duty_report_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_duty_report_tx
//  Purpose  : Directed self-checking bench for duty_report_tx. Unit 0 is
//             NEWLINE=1/ZERO_BLANK=0, unit 1 is NEWLINE=0/ZERO_BLANK=1.
//  Revision : 1.0  initial release
// ============================================================================
module tb_duty_report_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start    [2];
    logic [7:0] dt       [2];
    logic       tx_ready [2];
    logic [7:0] tx_data  [2];
    logic       tx_valid [2];
    logic       busy     [2];
    logic       done     [2];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    duty_report_tx #(.NEWLINE(1'b1), .ZERO_BLANK(1'b0)) u_dut_a (
        .clk(clk), .rst(rst), .start(start[0]), .dt(dt[0]),
        .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
        .busy(busy[0]), .done(done[0])
    );

    duty_report_tx #(.NEWLINE(1'b0), .ZERO_BLANK(1'b1)) u_dut_b (
        .clk(clk), .rst(rst), .start(start[1]), .dt(dt[1]),
        .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
        .busy(busy[1]), .done(done[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [63:0] msg, input int i);
        return msg[63 - 8*i -: 8];
    endfunction

    // Sends one report on unit u and checks every byte. bp >= 0 stalls
    // tx_ready for 5 cycles at that byte; inj pulses start with dt=99 once
    // during CONVERT and once during SEND.
    task automatic run_msg(input int u, input logic [7:0] d, input logic [63:0] msg,
                           input int len, input int bp, input bit inj);
        @(negedge clk);
        start[u] = 1'b1;
        dt[u]    = d;
        @(negedge clk);
        start[u] = 1'b0;
        check_eq("busy_after_accept", busy[u], 1);
        check_eq("valid_in_convert", tx_valid[u], 0);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (inj && i == 3) begin
                start[u] = 1'b1;
                dt[u]    = 8'd99;
            end else if (inj && i == 4) begin
                start[u] = 1'b0;
            end
        end
        for (int i = 0; i < len; i++) begin
            if (i == bp) begin
                tx_ready[u] = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check_eq("bp_data", tx_data[u], exp_byte(msg, i));
                    check_eq("bp_valid", tx_valid[u], 1);
                end
                tx_ready[u] = 1'b1;
            end
            check_eq("msg_byte", tx_data[u], exp_byte(msg, i));
            check_eq("msg_valid", tx_valid[u], 1);
            if (inj && i == 1) start[u] = 1'b1;
            if (inj && i == 2) start[u] = 1'b0;
            @(negedge clk);
        end
        check_eq("done_pulse", done[u], 1);
        check_eq("busy_end", busy[u], 0);
        check_eq("valid_end", tx_valid[u], 0);
        repeat (3) begin
            @(negedge clk);
            check_eq("done_single", done[u], 0);
            check_eq("idle_busy", busy[u], 0);
        end
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            start[u]    = 1'b0;
            dt[u]       = 8'd0;
            tx_ready[u] = 1'b1;
        end
        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check_eq("rst_data", tx_data[u], 0);
            check_eq("rst_valid", tx_valid[u], 0);
            check_eq("rst_busy", busy[u], 0);
            check_eq("rst_done", done[u], 0);
        end
        rst = 1'b0;

        run_msg(0, 8'd123, 64'h443D313233250D0A, 8, -1, 1'b0);
        run_msg(0, 8'd255, 64'h443D323535250D0A, 8, -1, 1'b0);
        run_msg(0, 8'd0,   64'h443D303030250D0A, 8, -1, 1'b0);
        run_msg(1, 8'd0,   64'h443D202030250000, 6, -1, 1'b0);
        run_msg(1, 8'd7,   64'h443D202037250000, 6, -1, 1'b0);
        run_msg(1, 8'd100, 64'h443D313030250000, 6, -1, 1'b0);
        run_msg(1, 8'd42,  64'h443D203432250000, 6, -1, 1'b0);
        run_msg(0, 8'd123, 64'h443D313233250D0A, 8, 3, 1'b0);
        run_msg(0, 8'd50,  64'h443D303530250D0A, 8, -1, 1'b1);

        // Reset while byte 4 is presented aborts immediately.
        @(negedge clk);
        start[0] = 1'b1;
        dt[0]    = 8'd200;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (12) @(negedge clk);
        check_eq("pre_rst_byte4", tx_data[0], 8'h30);
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_data", tx_data[0], 0);
        check_eq("async_rst_valid", tx_valid[0], 0);
        check_eq("async_rst_busy", busy[0], 0);
        check_eq("async_rst_done", done[0], 0);
        @(negedge clk);
        rst = 1'b0;
        run_msg(0, 8'd10, 64'h443D303130250D0A, 8, -1, 1'b0);

        // Back-to-back with start held high; dt changes mid-message only
        // affect the following message.
        @(negedge clk);
        start[1] = 1'b1;
        dt[1]    = 8'd5;
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            logic [63:0] msg;
            msg = (m == 0) ? 64'h443D202035250000 : 64'h443D313530250000;
            check_eq("b2b_busy_start", busy[1], 1);
            repeat (8) @(negedge clk);
            for (int i = 0; i < 6; i++) begin
                check_eq("b2b_byte", tx_data[1], exp_byte(msg, i));
                check_eq("b2b_valid", tx_valid[1], 1);
                if (m == 0 && i == 2) dt[1] = 8'd150;
                @(negedge clk);
            end
            check_eq("b2b_done", done[1], 1);
            check_eq("b2b_busy_done", busy[1], 0);
            @(negedge clk);
            check_eq("b2b_done_clear", done[1], 0);
        end
        start[1] = 1'b0;
        check_eq("b2b_third_busy", busy[1], 1);
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
